// File: rtl/mem_ctrl.sv
// Arbitrates the load/store queue (priority) and instruction fetch onto a byte-wide RAM; optional MEM_CTRL_IO_GUARD_EN stalls I/O-window stores.
// Latency: n+1 cycles from the first address to the success pulse for n-byte reads; n cycles for writes; one IDLE cycle between accesses.
// Backpressure: stores are absorbed in an LSB_Q_DEPTH queue flagged by lsb_req_full; rdy low freezes everything.
module mem_ctrl #(
    parameter int         LSB_Q_DEPTH = 4,
    parameter logic [1:0] IO_BASE_HI  = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_flag,
    input  logic        mem_enable,
    input  logic [2:0]  op_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wr_tag,
    output logic        mem_success,
    output logic [31:0] mem_rdata,
    output logic        lsb_req_full,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_success,
    output logic [31:0] if_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full
);
    localparam int PW = $clog2(LSB_Q_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_TH = CW'(LSB_Q_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LSB_RD, LSB_WR, IF_RD} state_t;
    typedef struct packed {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t          q_mem [LSB_Q_DEPTH];
    req_t          head, q_in;
    logic [PW-1:0] q_head, q_tail, q_last, q_widx;
    logic [CW-1:0] q_cnt, q_cnt_nxt;
    logic          q_push, q_pop, q_drop;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt, size;
    logic [31:0] base, wdata, rbuf, rd_word, addr_cur;
    logic        stall, start_if, reading, rd_done;

    assign head   = q_mem[q_head];
    assign q_in   = '{wr: mem_wr_tag, size: op_size, addr: mem_addr, wdata: mem_wdata};
    assign q_last = q_tail - PW'(1);

    // A flushed load is never enqueued; a queued load is always the tail entry.
    assign q_push    = rdy && mem_enable && !(jump_flag && !mem_wr_tag);
    assign q_drop    = rdy && jump_flag && (q_cnt != '0) && !q_mem[q_last].wr;
    assign q_pop     = rdy && (state == IDLE) && (q_cnt != '0) && !(q_drop && q_cnt == CW'(1));
    assign q_widx    = q_drop ? q_last : q_tail;
    assign q_cnt_nxt = q_cnt + CW'(q_push) - CW'(q_pop) - CW'(q_drop);

    assign start_if = rdy && (state == IDLE) && (q_cnt == '0) && if_enable && !jump_flag;
    assign reading  = (state == LSB_RD) || (state == IF_RD);
    assign rd_done  = (cnt == size);
    assign addr_cur = base + 32'(cnt);
    // Byte cnt-1 arrives on ram_din one cycle after its address.
    assign rd_word  = rbuf | (32'(ram_din) << {cnt - 3'd1, 3'b000});

`ifdef MEM_CTRL_IO_GUARD_EN
    assign stall = (state == LSB_WR) && io_buffer_full && (addr_cur[17:16] == IO_BASE_HI);
`else
    assign stall = 1'b0 & io_buffer_full;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (q_pop) begin
                        state_nxt = head.wr ? LSB_WR : LSB_RD;
                        cnt_nxt   = 3'd0;
                    end else if (start_if) begin
                        state_nxt = IF_RD;
                        cnt_nxt   = 3'd0;
                    end
                end
                LSB_RD, IF_RD: begin
                    if (jump_flag || rd_done) state_nxt = IDLE;
                    else                      cnt_nxt   = cnt + 3'd1;
                end
                LSB_WR: begin
                    if (!stall) begin
                        if (cnt == size - 3'd1) state_nxt = IDLE;
                        else                    cnt_nxt   = cnt + 3'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ram_a    = '0;
        ram_dout = '0;
        ram_wr   = 1'b0;
        if (state != IDLE) ram_a = addr_cur;
        if (state == LSB_WR) begin
            ram_dout = 8'(wdata >> {cnt, 3'b000});
            ram_wr   = rdy && !stall;
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) q_mem[q_widx] <= q_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            size         <= '0;
            base         <= '0;
            wdata        <= '0;
            rbuf         <= '0;
            q_head       <= '0;
            q_tail       <= '0;
            q_cnt        <= '0;
            lsb_req_full <= 1'b0;
            mem_success  <= 1'b0;
            mem_rdata    <= '0;
            if_success   <= 1'b0;
            if_rdata     <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            q_cnt        <= q_cnt_nxt;
            q_head       <= q_head + PW'(q_pop);
            q_tail       <= q_tail + PW'(q_push) - PW'(q_drop);
            lsb_req_full <= (q_cnt_nxt >= FULL_TH);
            mem_success  <= 1'b0;
            if_success   <= 1'b0;
            if (q_pop) begin
                size  <= head.size;
                base  <= head.addr;
                wdata <= head.wdata;
                rbuf  <= '0;
            end else if (start_if) begin
                size <= 3'd4;
                base <= if_addr;
                rbuf <= '0;
            end
            if (rdy && reading && cnt != 3'd0) rbuf <= rd_word;
            if (rdy && reading && rd_done && !jump_flag) begin
                if (state == LSB_RD) begin
                    mem_success <= 1'b1;
                    mem_rdata   <= rd_word;
                end else begin
                    if_success <= 1'b1;
                    if_rdata   <= rd_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-RAM model, expected responses/writes queued at stimulus time.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
`timescale 1ns/1ps
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, jump_flag, mem_enable, mem_wr_tag, if_enable, io_buffer_full;
    logic [2:0]  op_size;
    logic [31:0] mem_addr, mem_wdata, if_addr;
    logic        mem_success, if_success, lsb_req_full, ram_wr;
    logic [31:0] mem_rdata, if_rdata, ram_a;
    logic [7:0]  ram_din, ram_dout;

    logic [7:0]  ram [0:262143];
    logic [31:0] exp_if[$], exp_mem[$];
    logic [39:0] exp_wr[$];
    logic [31:0] e;
    logic [39:0] w;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
        .mem_enable(mem_enable), .op_size(op_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr_tag(mem_wr_tag), .mem_success(mem_success),
        .mem_rdata(mem_rdata), .lsb_req_full(lsb_req_full), .if_enable(if_enable),
        .if_addr(if_addr), .if_success(if_success), .if_rdata(if_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    always @(posedge clk) begin
        if (ram_wr === 1'b1) ram[ram_a[17:0]] <= ram_dout;
        ram_din <= ram[ram_a[17:0]];
    end

    always @(posedge clk)
        if (rst === 1'b0 && rdy && mem_enable)
            assert (!(dut.q_cnt == 3'd4 && !dut.q_pop))
            else $error("FAIL push_full: push while queue holds 4 entries");

    // Scoreboard: every response and every RAM write is matched in order.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (if_success === 1'b1) begin
                total++;
                if (exp_if.size() == 0) begin
                    bad++; $display("FAIL if_unexpected: if_rdata=%h, no fetch expected", if_rdata);
                end else begin
                    e = exp_if.pop_front();
                    if (if_rdata !== e) begin bad++; $display("FAIL if_rdata: got %h want %h", if_rdata, e); end
                end
                if_enable = 1'b0;
            end
            if (mem_success === 1'b1) begin
                total++;
                if (exp_mem.size() == 0) begin
                    bad++; $display("FAIL mem_unexpected: mem_rdata=%h, no load expected", mem_rdata);
                end else begin
                    e = exp_mem.pop_front();
                    if (mem_rdata !== e) begin bad++; $display("FAIL mem_rdata: got %h want %h", mem_rdata, e); end
                end
            end
            if (ram_wr === 1'b1) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++; $display("FAIL wr_unexpected: a=%h d=%h, no write expected", ram_a, ram_dout);
                end else begin
                    w = exp_wr.pop_front();
                    if ({ram_a, ram_dout} !== w) begin
                        bad++; $display("FAIL ram_write: got a=%h d=%h want a=%h d=%h", ram_a, ram_dout, w[39:8], w[7:0]);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lsb_issue(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        mem_enable = 1'b1; mem_wr_tag = wr; op_size = sz; mem_addr = a; mem_wdata = d;
        if (wr) for (int k = 0; k < int'(sz); k++) exp_wr.push_back({a + 32'(k), 8'(d >> (8 * k))});
        cyc();
        mem_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0; mem_enable = 1'b0; mem_wr_tag = 1'b0;
        op_size = 3'd1; mem_addr = '0; mem_wdata = '0; if_enable = 1'b0; if_addr = '0; io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ram_a, ram_dout, ram_wr} !== 41'h0) begin
            bad++; $display("FAIL reset_ram: got a=%h d=%h wr=%b want all 0", ram_a, ram_dout, ram_wr);
        end
        total++;
        if ({mem_success, mem_rdata, if_success, if_rdata, lsb_req_full} !== 67'h0) begin
            bad++; $display("FAIL reset_resp: got ms=%b md=%h is=%b id=%h full=%b want all 0",
                            mem_success, mem_rdata, if_success, if_rdata, lsb_req_full);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_fetch();
        int first = -1, lat = -1;
        if_addr = 32'h10; if_enable = 1'b1; exp_if.push_back(32'h4433_2211);
        for (int c = 0; c < 30 && lat < 0; c++) begin
            @(negedge clk);
            if (first < 0 && ram_a === 32'h10) first = c;
            if (if_success === 1'b1) lat = c - first;
        end
        total++;
        if (lat != 5) begin bad++; $display("FAIL fetch_latency: got %0d want 5", lat); end
        cyc();
    endtask

    task automatic test_load_byte();
        int first = -1, lat = -1, nif = 0;
        exp_mem.push_back(32'h0000_0080);
        lsb_issue(1'b0, 3'd1, 32'h20, 32'h0);
        for (int c = 0; c < 30 && lat < 0; c++) begin
            @(negedge clk);
            if (first < 0 && ram_a === 32'h20) first = c;
            if (if_success === 1'b1) nif++;
            if (mem_success === 1'b1) lat = c - first;
        end
        total++;
        if (lat != 2) begin bad++; $display("FAIL lb_latency: got %0d want 2", lat); end
        total++;
        if (nif != 0) begin bad++; $display("FAIL lb_no_fetch: got %0d if_success want 0", nif); end
        cyc();
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        if_addr = 32'h50; if_enable = 1'b1; exp_if.push_back(32'h0403_0201);
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = (ram_a === 32'h50); end
        total++;
        if (!seen) begin bad++; $display("FAIL b2b_fetch_start: got no fetch address want 00000050"); end
        cyc();
        lsb_issue(1'b1, 3'd4, 32'h100, 32'hA4A3_A2A1);
        lsb_issue(1'b1, 3'd4, 32'h104, 32'hB4B3_B2B1);
        lsb_issue(1'b1, 3'd4, 32'h108, 32'hC4C3_C2C1);
        @(negedge clk);
        total++;
        if (lsb_req_full !== 1'b1) begin bad++; $display("FAIL b2b_full: got %b want 1", lsb_req_full); end
        for (int c = 0; c < 60 && (exp_wr.size() != 0 || exp_if.size() != 0); c++) @(negedge clk);
        total++;
        if (exp_wr.size() != 0 || exp_if.size() != 0) begin
            bad++; $display("FAIL b2b_drain: got %0d writes %0d fetches pending want 0", exp_wr.size(), exp_if.size());
        end
        total++;
        if (lsb_req_full !== 1'b0) begin bad++; $display("FAIL b2b_full_clear: got %b want 0", lsb_req_full); end
        cyc();
    endtask

    task automatic test_jump_fetch();
        bit seen = 0;
        int nif = 0, first = -1, lat = -1;
        logic [31:0] a0 = '0;
        if_addr = 32'h10; if_enable = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = (ram_a === 32'h10); end
        cyc(); cyc();
        jump_flag = 1'b1; if_enable = 1'b0;
        cyc();
        jump_flag = 1'b0;
        repeat (8) begin @(negedge clk); if (if_success === 1'b1) nif++; end
        total++;
        if (nif != 0) begin bad++; $display("FAIL jump_fetch_abort: got %0d if_success want 0", nif); end
        cyc();
        if_enable = 1'b1; exp_if.push_back(32'h4433_2211);
        for (int c = 0; c < 30 && lat < 0; c++) begin
            @(negedge clk);
            if (first < 0 && ram_a !== 32'h0) begin first = c; a0 = ram_a; end
            if (if_success === 1'b1) lat = c - first;
        end
        total++;
        if (a0 !== 32'h10) begin bad++; $display("FAIL jump_refetch_addr: got %h want 00000010", a0); end
        total++;
        if (lat != 5) begin bad++; $display("FAIL jump_refetch_latency: got %0d want 5", lat); end
        cyc();
    endtask

    task automatic test_jump_queue();
        bit seen = 0;
        int nmem = 0, nif = 0;
        if_addr = 32'h50; if_enable = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = (ram_a === 32'h50); end
        cyc();
        lsb_issue(1'b1, 3'd4, 32'h200, 32'h0D0C_0B0A);
        lsb_issue(1'b0, 3'd4, 32'h10, 32'h0);
        jump_flag = 1'b1; if_enable = 1'b0;
        cyc();
        jump_flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (mem_success === 1'b1) nmem++;
            if (if_success === 1'b1) nif++;
        end
        total++;
        if (nmem != 0 || nif != 0) begin
            bad++; $display("FAIL jump_queue_resp: got mem=%0d if=%0d responses want 0", nmem, nif);
        end
        total++;
        if (exp_wr.size() != 0) begin bad++; $display("FAIL jump_queue_store: got %0d writes pending want 0", exp_wr.size()); end
        cyc();
    endtask

    task automatic test_priority();
        int mc = -1, ic = -1;
        lsb_issue(1'b1, 3'd4, 32'h300, 32'h3332_3130);
        exp_mem.push_back(32'h0000_BEEF); exp_if.push_back(32'h0403_0201);
        if_addr = 32'h50; if_enable = 1'b1;
        lsb_issue(1'b0, 3'd2, 32'h40, 32'h0);
        for (int c = 0; c < 60 && (mc < 0 || ic < 0); c++) begin
            @(negedge clk);
            if (mem_success === 1'b1 && mc < 0) mc = c;
            if (if_success === 1'b1 && ic < 0) ic = c;
        end
        total++;
        if (mc < 0 || ic <= mc) begin bad++; $display("FAIL priority_order: got lh@%0d fetch@%0d want lh first", mc, ic); end
        cyc();
    endtask

    task automatic test_wrap();
        int first = -1, lat = -1;
        exp_mem.push_back(32'h0000_7E5C);
        lsb_issue(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0);
        for (int c = 0; c < 30 && lat < 0; c++) begin
            @(negedge clk);
            if (first < 0 && ram_a === 32'hFFFF_FFFF) first = c;
            if (mem_success === 1'b1) lat = c - first;
        end
        total++;
        if (lat != 3) begin bad++; $display("FAIL wrap_latency: got %0d want 3", lat); end
        cyc();
    endtask

    task automatic test_rdy_freeze();
        bit seen = 0;
        int nfz = 0;
        lsb_issue(1'b1, 3'd4, 32'h400, 32'hD4C3_B2A1);
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = (ram_wr === 1'b1); end
        cyc();
        rdy = 1'b0;
        repeat (3) begin @(negedge clk); if (ram_wr !== 1'b0) nfz++; cyc(); end
        rdy = 1'b1;
        total++;
        if (nfz != 0) begin bad++; $display("FAIL rdy_wr_low: got %0d writes while frozen want 0", nfz); end
        for (int c = 0; c < 20 && exp_wr.size() != 0; c++) @(negedge clk);
        total++;
        if (exp_wr.size() != 0) begin bad++; $display("FAIL rdy_resume: got %0d writes pending want 0", exp_wr.size()); end
        cyc();
    endtask

    task automatic test_io_guard();
        int n = 0;
        io_buffer_full = 1'b1;
        lsb_issue(1'b1, 3'd1, 32'h2_0001, 32'h66);
        repeat (6) begin @(negedge clk); if (ram_wr === 1'b1) n++; end
        total++;
        if (n != 1) begin bad++; $display("FAIL io_outside_window: got %0d writes want 1", n); end
        cyc();
        n = 0;
        lsb_issue(1'b1, 3'd1, 32'h3_0000, 32'h5A);
`ifdef MEM_CTRL_IO_GUARD_EN
        repeat (6) begin @(negedge clk); if (ram_wr === 1'b1) n++; end
        total++;
        if (n != 0) begin bad++; $display("FAIL io_stall: got %0d writes while full want 0", n); end
        cyc();
        io_buffer_full = 1'b0;
        n = 0;
`endif
        repeat (6) begin @(negedge clk); if (ram_wr === 1'b1) n++; end
        total++;
        if (n != 1) begin bad++; $display("FAIL io_write: got %0d writes want 1", n); end
        cyc();
        io_buffer_full = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[32'h10] = 8'h11; ram[32'h11] = 8'h22; ram[32'h12] = 8'h33; ram[32'h13] = 8'h44;
        ram[32'h20] = 8'h80;
        ram[32'h40] = 8'hEF; ram[32'h41] = 8'hBE;
        ram[32'h50] = 8'h01; ram[32'h51] = 8'h02; ram[32'h52] = 8'h03; ram[32'h53] = 8'h04;
        ram[32'h3FFFF] = 8'h5C; ram[0] = 8'h7E;
        test_reset();
        test_fetch();
        test_load_byte();
        test_back_to_back();
        test_jump_fetch();
        test_jump_queue();
        test_priority();
        test_wrap();
        test_rdy_freeze();
        test_io_guard();
        repeat (3) cyc();
        total++;
        if (exp_if.size() + exp_mem.size() + exp_wr.size() != 0) begin
            bad++; $display("FAIL final_drain: got %0d/%0d/%0d pending want 0", exp_if.size(), exp_mem.size(), exp_wr.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the core and the byte-wide unified RAM. It arbitrates between instruction fetch and the load/store buffer, and breaks each 1/2/4-byte access into per-byte RAM cycles. It assembles little-endian read data and returns it to the requester. Fire-and-forget store pulses from the load/store buffer are absorbed in a small request queue, so the buffer never waits on a store.

## Interface
- LSB_Q_DEPTH, 4: load/store request queue entries (power of two, ≥2)
- IO_BASE_HI, 2'b11: value of addr[17:16] that marks the I/O window
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rdy  input  1  global enable; low freezes the block
- jump_flag  input  1  misprediction flush
- mem_enable  input  1  LSB request strobe (one-cycle pulse or held)
- op_size  input  3  byte count: 3'b001, 3'b010 or 3'b100
- mem_addr  input  32  LSB byte address
- mem_wdata  input  32  store data; low op_size bytes are used
- mem_wr_tag  input  1  1 = store, 0 = load
- mem_success  output  1  one-cycle pulse: load data valid (never pulsed for stores)
- mem_rdata  output  32  load data, zero-extended
- lsb_req_full  output  1  queue holds ≥ LSB_Q_DEPTH-1 entries
- if_enable  input  1  fetch request, held until if_success
- if_addr  input  32  fetch address
- if_success  output  1  one-cycle pulse: if_rdata valid
- if_rdata  output  32  fetched word
- ram_din  input  8  RAM read byte, valid the cycle after its address
- ram_dout  output  8  RAM write byte
- ram_a  output  32  RAM byte address
- ram_wr  output  1  1 = write this cycle
- io_buffer_full  input  1  UART output buffer full

## Operation
- Queue push: mem_enable high and rdy high. Each entry holds {wr, size, addr, wdata}. Push and pop in the same cycle are legal. Push while actually full is a bench assertion failure.
- At most one load is outstanding, because the LSB blocks after issuing a load. A queued load is therefore always the youngest entry.
- FSM states: IDLE, LSB_RD, LSB_WR, IF_RD. The byte counter cnt is 3 bits.
- IDLE with queue non-empty: pop the head, go to LSB_RD or LSB_WR, cnt=0.
- IDLE with queue empty and if_enable high: go to IF_RD with size 4.
- The queue has priority over fetch. A started access is never preempted.
- Read of n bytes: in cycle k (k=0..n-1) drive ram_a=base+k, ram_wr=0. Byte k is captured from ram_din in cycle k+1 into bits [8k+7:8k]. Unused upper bytes are 0.
- End of read: the success pulse and data are registered in the cycle after the last byte is captured. Then return to IDLE.
- Write of n bytes: in cycle k drive ram_a=base+k, ram_dout=wdata[8k+7:8k], ram_wr=1. Return to IDLE after byte n-1.
- jump_flag, current state IF_RD or LSB_RD: abort to IDLE. No success pulse is raised.
- jump_flag, youngest queue entry is a load: discard it.
- jump_flag, load pushed the same cycle: not enqueued.
- jump_flag never affects stores, whether queued or in LSB_WR.
- rdy=0: state, counter and queue hold. ram_wr is driven 0 and success pulses are 0. The frozen byte is reissued when rdy returns.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Reset values: ram_a=0, ram_dout=0, ram_wr=0, mem_success=0, mem_rdata=0, if_success=0, if_rdata=0, lsb_req_full=0. FSM=IDLE, queue empty.

## Timing
- Load/fetch latency, from the first address cycle to the success pulse: n+1 cycles. Example: lw is 5 cycles, lb is 2 cycles.
- Write occupancy: n cycles. There is no response.
- The IDLE decision costs one cycle between accesses.
- A request pushed into an empty queue while in IDLE starts its first address cycle 2 cycles after the mem_enable edge.
- if_enable is sampled only in IDLE. if_addr must be stable from IDLE until if_success.
- lsb_req_full is registered from the post-update count.

## Configuration
- MEM_CTRL_IO_GUARD_EN defined: a store write cycle stalls while io_buffer_full=1 and its address has addr[17:16]==IO_BASE_HI.
  - During the stall: counter held, ram_wr=0.
  - The stall applies to the cycle that would write; writes outside the I/O window are unaffected.
- Undefined: io_buffer_full is ignored.

## Test plan
- Fetch word 0x0000_0010 from RAM bytes 11,22,33,44 -> if_success 5 cycles after the first address, if_rdata=0x4433_2211.
- lb from a byte holding 0x80 -> mem_success with mem_rdata=0x0000_0080; no if_success in between.
- Three back-to-back sw pulses to 0x100, 0x104, 0x108 -> 12 write cycles in order, little-endian bytes, lsb_req_full asserted after the third push, no mem_success.
- jump_flag 2 cycles into an IF_RD -> no if_success; the next if_enable restarts at byte 0. jump_flag during a queued sw then lw -> sw written, lw dropped.
- if_enable and mem_enable (lh) both pending at IDLE -> lh served first, then the fetch.
- MEM_CTRL_IO_GUARD_EN with io_buffer_full=1, sb to 0x30000 -> ram_wr held 0 until io_buffer_full falls, then a single write.
